// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with flush, automatic bubble
// insertion behind a stalled upstream stage, and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W    = 64,
    parameter int CTRL_W    = 3,
    parameter int STALL_W   = 6,
    parameter int STALL_BIT = 3,
    parameter int BUBBLE_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall_state,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } action_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    action_t action;
    logic    upstream_stalled;
    logic    unused_stall_bits;

    // The upstream hold bit only exists for a stage that has an upstream neighbour.
    generate
        if (BUBBLE_EN != 0 && STALL_BIT > 0) begin : g_bubble
            assign upstream_stalled = stall_state[STALL_BIT-1];
        end else begin : g_no_bubble
            assign upstream_stalled = 1'b0;
        end
    endgenerate

    // Other stages' hold bits ride on the shared bus but do not affect this one.
    assign unused_stall_bits = ^stall_state;

    // NOTE: the default assignment before the if-chain keeps this purely
    // combinational; leaving any path unassigned would infer a latch.
    always_comb begin
        action = ACT_LOAD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (stall_state[STALL_BIT]) begin
            action = ACT_HOLD;
        end else if (upstream_stalled) begin
            action = ACT_BUBBLE;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            case (action)
                ACT_LOAD: begin
                    out_valid <= in_valid;
                    out_ctrl  <= in_valid ? in_ctrl : '0;
                    out_data  <= in_data;
                end
                ACT_HOLD: begin
                end
                ACT_BUBBLE, ACT_FLUSH: begin
                    // Payload is left alone; a zero valid/ctrl is enough to kill it.
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                end
                default: begin
                end
            endcase

            if (cnt_clr) begin
                stall_cnt  <= '0;
                bubble_cnt <= '0;
            end else begin
                if (action == ACT_HOLD && stall_cnt != CNT_MAX) begin
                    stall_cnt <= stall_cnt + CNT_ONE;
                end
                if ((action == ACT_BUBBLE || action == ACT_FLUSH) && bubble_cnt != CNT_MAX) begin
                    bubble_cnt <= bubble_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table-driven main sequence on the default
// configuration plus hand sequences for BUBBLE_EN=0 and CNT_W=2 saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_state;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_ctrl;
    logic [63:0] in_data;
    logic        cnt_clr;

    logic        a_valid, b_valid, c_valid;
    logic [2:0]  a_ctrl, b_ctrl, c_ctrl;
    logic [63:0] a_data, b_data, c_data;
    logic [15:0] a_scnt, a_bcnt, b_scnt, b_bcnt;
    logic [1:0]  c_scnt, c_bcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall_state(stall_state), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(a_valid), .out_ctrl(a_ctrl), .out_data(a_data),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
    );

    pipe_stage_reg #(.BUBBLE_EN(0)) dut_b (
        .clk(clk), .rst(rst), .stall_state(stall_state), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(b_valid), .out_ctrl(b_ctrl), .out_data(b_data),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .stall_state(stall_state), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_valid(c_valid), .out_ctrl(c_ctrl), .out_data(c_data),
        .stall_cnt(c_scnt), .bubble_cnt(c_bcnt)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic        v;
        logic [2:0]  c;
        logic [63:0] d;
        logic        clr;
        logic        ev;
        logic [2:0]  ec;
        logic [63:0] ed;
        logic [15:0] es;
        logic [15:0] eb;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic r, logic [5:0] s, logic f, logic v, logic [2:0] c,
                                logic [63:0] d, logic clr, logic ev, logic [2:0] ec,
                                logic [63:0] ed, logic [15:0] es, logic [15:0] eb);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.v = v; t.c = c; t.d = d; t.clr = clr;
        t.ev = ev; t.ec = ec; t.ed = ed; t.es = es; t.eb = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic f, input logic v,
                        input logic [2:0] c, input logic [63:0] d, input logic clr);
        rst = r; stall_state = s; flush = f; in_valid = v; in_ctrl = c; in_data = d;
        cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Invariant holds on every instance in every post-reset cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (!a_valid && a_ctrl != 3'b0) $error("FAIL inv_a: ctrl=%0b with valid=0", a_ctrl);
            if (!b_valid && b_ctrl != 3'b0) $error("FAIL inv_b: ctrl=%0b with valid=0", b_ctrl);
            if (!c_valid && c_ctrl != 3'b0) $error("FAIL inv_c: ctrl=%0b with valid=0", c_ctrl);
        end
    end

    initial begin
        //                rst stall      fl v  c       d         clr  ev ec      ed        es  eb
        vecs[0]  = mk(1, 6'b000000, 0, 0, 3'b000, 64'h0,    0,   0, 3'b000, 64'h0,    0,  0);
        vecs[1]  = mk(1, 6'b000000, 0, 1, 3'b111, 64'h55,   0,   0, 3'b000, 64'h0,    0,  0);
        vecs[2]  = mk(0, 6'b000000, 0, 1, 3'b101, 64'h1234, 0,   1, 3'b101, 64'h1234, 0,  0);
        vecs[3]  = mk(0, 6'b001000, 0, 1, 3'b111, 64'hFFFF, 0,   1, 3'b101, 64'h1234, 1,  0);
        vecs[4]  = mk(0, 6'b001000, 0, 1, 3'b111, 64'hFFFF, 0,   1, 3'b101, 64'h1234, 2,  0);
        vecs[5]  = mk(0, 6'b001000, 0, 1, 3'b111, 64'hFFFF, 0,   1, 3'b101, 64'h1234, 3,  0);
        vecs[6]  = mk(0, 6'b001000, 0, 1, 3'b111, 64'hFFFF, 0,   1, 3'b101, 64'h1234, 4,  0);
        vecs[7]  = mk(0, 6'b000100, 0, 1, 3'b111, 64'hFFFF, 0,   0, 3'b000, 64'h1234, 4,  1);
        vecs[8]  = mk(0, 6'b000100, 0, 1, 3'b111, 64'hFFFF, 0,   0, 3'b000, 64'h1234, 4,  2);
        vecs[9]  = mk(0, 6'b000000, 0, 1, 3'b011, 64'hABCD, 0,   1, 3'b011, 64'hABCD, 4,  2);
        vecs[10] = mk(0, 6'b001000, 1, 1, 3'b111, 64'h5555, 0,   0, 3'b000, 64'hABCD, 4,  3);
        vecs[11] = mk(0, 6'b000000, 0, 0, 3'b111, 64'h7777, 0,   0, 3'b000, 64'h7777, 4,  3);
        vecs[12] = mk(0, 6'b000000, 0, 1, 3'b110, 64'h8888, 0,   1, 3'b110, 64'h8888, 4,  3);
        vecs[13] = mk(0, 6'b000001, 0, 1, 3'b001, 64'h9999, 0,   1, 3'b001, 64'h9999, 4,  3);
        vecs[14] = mk(0, 6'b110000, 0, 1, 3'b010, 64'hAAAA, 0,   1, 3'b010, 64'hAAAA, 4,  3);
        vecs[15] = mk(0, 6'b000000, 1, 1, 3'b111, 64'h1111, 0,   0, 3'b000, 64'hAAAA, 4,  4);
        vecs[16] = mk(0, 6'b001100, 0, 1, 3'b111, 64'h2222, 0,   0, 3'b000, 64'hAAAA, 5,  4);
        vecs[17] = mk(0, 6'b001000, 0, 1, 3'b111, 64'h3333, 1,   0, 3'b000, 64'hAAAA, 0,  0);
        vecs[18] = mk(0, 6'b000000, 0, 1, 3'b100, 64'hBBBB, 1,   1, 3'b100, 64'hBBBB, 0,  0);
        vecs[19] = mk(0, 6'b001000, 0, 1, 3'b111, 64'h4444, 0,   1, 3'b100, 64'hBBBB, 1,  0);
        vecs[20] = mk(1, 6'b001000, 1, 1, 3'b111, 64'h6666, 0,   0, 3'b000, 64'h0,    0,  0);
        vecs[21] = mk(0, 6'b000000, 0, 1, 3'b101, 64'hCCCC, 0,   1, 3'b101, 64'hCCCC, 0,  0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].v, vecs[i].c,
                 vecs[i].d, vecs[i].clr);
            check($sformatf("v%0d_valid", i), {63'b0, a_valid}, {63'b0, vecs[i].ev});
            check($sformatf("v%0d_ctrl", i),  {61'b0, a_ctrl},  {61'b0, vecs[i].ec});
            check($sformatf("v%0d_data", i),  a_data,           vecs[i].ed);
            check($sformatf("v%0d_scnt", i),  {48'b0, a_scnt},  {48'b0, vecs[i].es});
            check($sformatf("v%0d_bcnt", i),  {48'b0, a_bcnt},  {48'b0, vecs[i].eb});
        end

        // Upstream stall with bubbles disabled: dut_b loads, dut_a bubbles.
        step(1, 6'b000000, 0, 0, 3'b000, 64'h0, 0);
        for (int i = 1; i <= 2; i++) begin
            step(0, 6'b000100, 0, 1, 3'b111, 64'hDDDD + 64'(i), 0);
            check("nobub_valid", {63'b0, b_valid}, 64'd1);
            check("nobub_ctrl",  {61'b0, b_ctrl},  64'd7);
            check("nobub_data",  b_data,           64'hDDDD + 64'(i));
            check("nobub_bcnt",  {48'b0, b_bcnt},  64'd0);
            check("bub_valid",   {63'b0, a_valid}, 64'd0);
            check("bub_data",    a_data,           64'h0);
            check("bub_bcnt",    {48'b0, a_bcnt},  64'(i));
        end

        // Two-bit counters saturate at 3 and clear wins over increment.
        step(1, 6'b000000, 0, 0, 3'b000, 64'h0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 6'b001000, 0, 1, 3'b111, 64'hEEEE, 0);
            check($sformatf("sat_scnt%0d", i), {62'b0, c_scnt}, (i < 3) ? 64'(i) : 64'd3);
        end
        check("sat_a_scnt", {48'b0, a_scnt}, 64'd6);
        step(0, 6'b001000, 0, 1, 3'b111, 64'hEEEE, 1);
        check("clr_scnt", {62'b0, c_scnt}, 64'd0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 6'b000000, 1, 1, 3'b111, 64'hEEEE, 0);
            check($sformatf("sat_bcnt%0d", i), {62'b0, c_bcnt}, (i < 3) ? 64'(i) : 64'd3);
            check($sformatf("sat_flush_scnt%0d", i), {62'b0, c_scnt}, 64'd0);
        end
        check("sat_flush_valid", {63'b0, c_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed-field EX/MEM latch.
- Carries an opaque payload bus plus a side-effect control bus (modify/load/save-type flags), with a valid bit.
- Adds flush, automatic bubble insertion when the upstream stage stalls, and saturating stall/bubble performance counters.
- One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), selected by STALL_BIT.

Parameters:
DATA_W, 64, payload width in bits (non-side-effect fields: addresses, data, lengths)
CTRL_W, 3, side-effect control flag width; forced to 0 on any bubble or flush
STALL_W, 6, width of the shared stall_state bus
STALL_BIT, 3, index of this stage's hold bit in stall_state; range 0..STALL_W-1
BUBBLE_EN, 1, 1 = insert bubble when stall_state[STALL_BIT-1]=1 and own bit=0; ignored when STALL_BIT=0
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
stall_state  in  STALL_W  stall vector from stall bus; bit STALL_BIT=1 holds this register
flush  in  1  discard stage contents (branch mispredict / exception)
in_valid  in  1  upstream entry valid
in_ctrl  in  CTRL_W  upstream side-effect flags
in_data  in  DATA_W  upstream payload
cnt_clr  in  1  synchronous clear of both counters
out_valid  out  1  registered valid
out_ctrl  out  CTRL_W  registered side-effect flags; always 0 when out_valid=0
out_data  out  DATA_W  registered payload
stall_cnt  out  CNT_W  cycles spent in HOLD
bubble_cnt  out  CNT_W  cycles spent in BUBBLE or FLUSH

Behaviour:
- All outputs registered; update on rising clk only; no combinational in->out paths.
- Reset (rst=1): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, bubble_cnt=0. Overrides every other input, including mid-stall or mid-flush.
- Per-cycle action, highest priority first:
  1. FLUSH (flush=1): out_valid<=0; out_ctrl<=0; out_data holds. Flush wins even when own stall bit=1.
  2. HOLD (stall_state[STALL_BIT]=1): all of out_valid, out_ctrl, out_data hold.
  3. BUBBLE (BUBBLE_EN=1, STALL_BIT>0, stall_state[STALL_BIT-1]=1): out_valid<=0; out_ctrl<=0; out_data holds. Prevents a stalled upstream entry from being committed twice downstream.
  4. LOAD (otherwise): out_valid<=in_valid; out_ctrl<=in_valid ? in_ctrl : 0; out_data<=in_data.
- Invariant: out_valid=0 implies out_ctrl=0 in every cycle after reset.
- Counters, evaluated in the same cycle as the action above:
  - cnt_clr=1 (rst=0): both counters <=0; clear takes priority over increment.
  - HOLD: stall_cnt+1.
  - BUBBLE or FLUSH: bubble_cnt+1.
  - Both counters saturate at 2^CNT_W-1, with no wrap.
  - Only one counter increments per cycle.
- STALL_BIT=0 or BUBBLE_EN=0: BUBBLE is never taken; stall_state[STALL_BIT-1] is not referenced.
- Throughput: 1 entry/cycle; latency: 1 cycle from in_* to out_*.

Test Plan:
- Reset then LOAD: rst 2 cycles, then in_valid=1, in_ctrl=3'b101, in_data=0x1234, stall_state=0 -> next cycle out_valid=1, out_ctrl=3'b101, out_data=0x1234; counters 0.
- HOLD: after load, stall_state=6'b001000 for 4 cycles while in_data changes to 0xFFFF -> outputs stay 0x1234/3'b101/1; stall_cnt=4.
- BUBBLE: stall_state=6'b000100 for 2 cycles with in_valid=1, in_ctrl=3'b111 -> out_valid=0, out_ctrl=0, out_data unchanged; bubble_cnt=2. Repeat with BUBBLE_EN=0 -> entry loads normally.
- Flush vs hold: stall_state[3]=1 and flush=1 in the same cycle -> out_valid=0, out_ctrl=0, bubble_cnt+1, stall_cnt unchanged.
- Saturation and clear: CNT_W=2, hold 6 cycles -> stall_cnt=3. Then cnt_clr=1 together with hold -> stall_cnt=0 the next cycle.
- Reset mid-operation: rst=1 during HOLD with flush=1 -> all outputs and counters 0 the next cycle.
